// File: rtl/amp_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : amp_seq_pkg
// Brief    : Shared state encoding, command fields and helpers for the sequencer
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package amp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_RELAY    = 3'd2,
    ST_STAGGER  = 3'd3,
    ST_RUN      = 3'd4,
    ST_FAULT    = 3'd5
  } seq_state_e;

  localparam int PWR_REQ_BIT = 0;
  localparam int CLR_BIT     = 1;
  localparam int MASK_LSB    = 4;
  localparam int MASK_MSB    = 7;

  localparam logic [7:0] CMD_ADDR_DEFAULT = 8'h0C;

  // Isolates the least-significant set bit (axis1 has priority).
  function automatic logic [3:0] lowest_bit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_timer.sv
//------------------------------------------------------------------------------
// Module   : seq_timer
// Brief    : Loadable saturating up-counter with terminal-count compare
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_timer #(
  parameter  int MAX_CYC = 16,
  localparam int W       = $clog2(MAX_CYC + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_hit
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en && (r_count != W'(MAX_CYC))) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires on the last cycle of an i_limit-cycle dwell.
  assign o_hit = (r_count == (i_limit - 1'b1));

endmodule

`default_nettype wire

// File: rtl/amp_power_sequencer.sv
//------------------------------------------------------------------------------
// Module   : amp_power_sequencer
// Brief    : QLA motor power / relay / amplifier-enable sequencer with fault
//            handling. Define AMP_SEQ_WDOG_EN to include the host watchdog.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module amp_power_sequencer
  import amp_seq_pkg::*;
#(
  parameter int         SETTLE_CYC  = 49152,
  parameter int         RELAY_CYC   = 24576,
  parameter int         STAGGER_CYC = 4915,
  parameter int         WDOG_CYC    = 4915200,
  parameter logic [7:0] CMD_ADDR    = CMD_ADDR_DEFAULT
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        reg_wen,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic        mv_good,
  input  logic [3:0]  fault,
  input  logic [3:0]  safety_amp_disable,
  output logic        pwr_enable,
  output logic        relay_on,
  output logic [3:0]  amp_enable,
  output logic [3:0]  axis_fault,
  output logic        wdog_expired,
  output logic [2:0]  seq_state
);

  localparam int DWELL_MAX =
    (SETTLE_CYC > RELAY_CYC) ?
      ((SETTLE_CYC > STAGGER_CYC) ? SETTLE_CYC : STAGGER_CYC) :
      ((RELAY_CYC  > STAGGER_CYC) ? RELAY_CYC  : STAGGER_CYC);
  localparam int DW = $clog2(DWELL_MAX + 1);

  seq_state_e r_state;
  seq_state_e w_next_state;
  logic [3:0] r_mask;
  logic [3:0] r_armed;
  logic [3:0] r_amp;
  logic [3:0] r_af;
  logic       r_pwr;
  logic       r_relay;
  logic       r_wd;

  logic          w_cmd;
  logic          w_preq;
  logic          w_clr;
  logic          w_abort;
  logic [3:0]    w_mask_next;
  logic [3:0]    w_trip;
  logic [3:0]    w_af_next;
  logic          w_wd_next;
  logic          w_supply_lost;
  logic          w_expire;
  logic [3:0]    w_pending;
  logic [3:0]    w_armed_next;
  logic          w_step;
  logic          w_dwell_hit;
  logic          w_dwell_load;
  logic [DW-1:0] w_dwell_limit;
  logic          w_unused;

  assign w_unused = ^{reg_wdata[31:8], reg_wdata[3:2]};

  always_comb begin
    w_cmd         = reg_wen && (reg_addr == CMD_ADDR);
    w_preq        = reg_wdata[PWR_REQ_BIT];
    w_clr         = w_cmd && reg_wdata[CLR_BIT];
    w_abort       = w_cmd && !w_preq;
    w_mask_next   = w_cmd ? reg_wdata[MASK_MSB:MASK_LSB] : r_mask;
    w_trip        = fault | safety_amp_disable;
    // A live trip input overrides a clear on the same cycle.
    w_af_next     = w_clr ? w_trip : (r_af | w_trip);
    w_wd_next     = w_expire | (r_wd & ~w_clr);
    w_supply_lost = !mv_good &&
                    ((r_state == ST_RELAY) || (r_state == ST_STAGGER) || (r_state == ST_RUN));
    w_pending     = w_mask_next & ~r_armed;
  end

  always_comb begin
    w_next_state = r_state;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd && w_preq && (w_af_next == 4'b0) && !w_wd_next)
          w_next_state = ST_PWR_WAIT;
      end
      ST_PWR_WAIT: begin
        if (w_expire || (!mv_good && w_dwell_hit)) w_next_state = ST_FAULT;
        else if (w_abort)                          w_next_state = ST_IDLE;
        else if (mv_good)                          w_next_state = ST_RELAY;
      end
      ST_RELAY: begin
        if (w_supply_lost || w_expire) w_next_state = ST_FAULT;
        else if (w_abort)              w_next_state = ST_IDLE;
        else if (w_dwell_hit)          w_next_state = ST_STAGGER;
      end
      ST_STAGGER: begin
        if (w_supply_lost || w_expire) w_next_state = ST_FAULT;
        else if (w_abort)              w_next_state = ST_IDLE;
        else if (w_pending == 4'b0)    w_next_state = ST_RUN;
        else if (w_dwell_hit)          w_step       = 1'b1;
      end
      ST_RUN: begin
        if (w_supply_lost || w_expire)                     w_next_state = ST_FAULT;
        else if (w_abort)                                  w_next_state = ST_IDLE;
        else if (w_cmd && w_preq && (w_pending != 4'b0))   w_next_state = ST_STAGGER;
      end
      ST_FAULT: begin
        if (w_clr && !w_preq) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Armed set tracks axes already sequenced on; it equals the mask in RUN.
  always_comb begin
    w_armed_next = 4'b0;
    if ((w_next_state == ST_STAGGER) || (w_next_state == ST_RUN))
      w_armed_next = (r_armed | (w_step ? lowest_bit(w_pending) : 4'b0)) & w_mask_next;
  end

  always_comb begin
    case (r_state)
      ST_PWR_WAIT: w_dwell_limit = DW'(SETTLE_CYC);
      ST_RELAY:    w_dwell_limit = DW'(RELAY_CYC);
      ST_STAGGER:  w_dwell_limit = DW'(STAGGER_CYC);
      default:     w_dwell_limit = DW'(DWELL_MAX);
    endcase
    w_dwell_load = (w_next_state != r_state) || w_step ||
                   !((r_state == ST_PWR_WAIT) || (r_state == ST_RELAY) || (r_state == ST_STAGGER));
  end

  seq_timer #(
    .MAX_CYC (DWELL_MAX)
  ) u_dwell (
    .clk     (sysclk),
    .rst_n   (reset),
    .i_load  (w_dwell_load),
    .i_en    (1'b1),
    .i_limit (w_dwell_limit),
    .o_hit   (w_dwell_hit)
  );

`ifdef AMP_SEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);

  logic w_active;
  logic w_wdog_hit;

  assign w_active = (r_state == ST_PWR_WAIT) || (r_state == ST_RELAY) ||
                    (r_state == ST_STAGGER)  || (r_state == ST_RUN);

  // Any host write refreshes; the count is parked at zero while idle or faulted.
  seq_timer #(
    .MAX_CYC (WDOG_CYC)
  ) u_wdog (
    .clk     (sysclk),
    .rst_n   (reset),
    .i_load  (reg_wen || !w_active),
    .i_en    (1'b1),
    .i_limit (WW'(WDOG_CYC)),
    .o_hit   (w_wdog_hit)
  );

  assign w_expire = w_wdog_hit && w_active && !reg_wen;
`else
  // No watchdog in this build; the parameter only keeps the interface uniform.
  assign w_expire = 1'b0 && (WDOG_CYC != 0);
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_mask  <= 4'b0;
      r_armed <= 4'b0;
      r_amp   <= 4'b0;
      r_af    <= 4'b0;
      r_pwr   <= 1'b0;
      r_relay <= 1'b0;
      r_wd    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_mask  <= w_mask_next;
      r_armed <= w_armed_next;
      r_amp   <= w_armed_next & ~w_af_next;
      r_af    <= w_af_next;
      r_wd    <= w_wd_next;
      r_pwr   <= (w_next_state == ST_PWR_WAIT) || (w_next_state == ST_RELAY) ||
                 (w_next_state == ST_STAGGER)  || (w_next_state == ST_RUN);
      r_relay <= (w_next_state == ST_RELAY) || (w_next_state == ST_STAGGER) ||
                 (w_next_state == ST_RUN);
    end
  end

  assign pwr_enable   = r_pwr;
  assign relay_on     = r_relay;
  assign amp_enable   = r_amp;
  assign axis_fault   = r_af;
  assign wdog_expired = r_wd;
  assign seq_state    = r_state;

endmodule

`default_nettype wire

// File: doc/amp_power_sequencer.md
# amp_power_sequencer

Sequences board power-up and amplifier enables for the four QLA axes. It drives motor power enable, the safety relay and the per-axis amplifier enables in a fixed order. It removes power on host-command loss (watchdog), motor-supply failure or per-axis safety events. It sits beside the channel-0 board registers on the sysclk domain, decodes one quadlet-write command register from the FireWire register bus, and feeds the board I/O pins.

## Interface
- SETTLE_CYC, 49152 (1 ms): max cycles from pwr_enable to mv_good before the supply is declared failed.
- RELAY_CYC, 24576: dwell cycles with relay_on asserted before amplifier enables begin.
- STAGGER_CYC, 4915: cycles between successive axis enables.
- WDOG_CYC, 4915200 (100 ms): cycles without any reg_wen before the watchdog expires.
- CMD_ADDR, 8'h0C: register address of the command quadlet.

Ports:
- sysclk  in  1  system clock, 49.152 MHz.
- reset  in  1  asynchronous, active-low reset.
- reg_wen  in  1  one-cycle register write strobe.
- reg_addr  in  8  register address.
- reg_wdata  in  32  write data.
  - bit0 = power request.
  - bit1 = clear faults.
  - [7:4] = axis enable mask, axis1 = bit4.
- mv_good  in  1  motor supply good, synchronous level.
- fault  in  4  amplifier fault, active high, bit0 = axis1.
- safety_amp_disable  in  4  current-safety trip, active high.
- pwr_enable  out  1  motor power enable.
- relay_on  out  1  safety relay drive.
- amp_enable  out  4  per-axis amplifier enable, active high; the top level inverts for the pins.
- axis_fault  out  4  latched per-axis fault.
- wdog_expired  out  1  latched watchdog expiry.
- seq_state  out  3  current state encoding, for status readback.

## Operation
- Command decode: a command is a cycle with reg_wen=1 and reg_addr==CMD_ADDR. It captures pwr_req, clr and amp_mask.
- IDLE (0): all outputs 0. Leave for PWR_WAIT when pwr_req=1 and no latched fault exists.
- PWR_WAIT (1): pwr_enable=1.
  - Go to RELAY on mv_good=1.
  - Go to FAULT if the counter reaches SETTLE_CYC first.
- RELAY (2): pwr_enable=1, relay_on=1. After RELAY_CYC cycles go to STAGGER.
- STAGGER (3): every STAGGER_CYC cycles, enable the lowest-index axis that is in amp_mask and not yet enabled. When none remain, go to RUN. An empty mask goes straight to RUN.
- RUN (4): amp_enable = amp_mask & ~axis_fault. A new command in RUN that adds mask bits returns to STAGGER for the added axes only.
- FAULT (5): all outputs 0. Go to IDLE when a command has clr=1 and pwr_req=0.
- Global abort: a command with pwr_req=0 from any non-FAULT state goes to IDLE.
- Supply loss: mv_good=0 in RELAY, STAGGER or RUN goes to FAULT.
- Axis fault: fault[i] or safety_amp_disable[i] sets axis_fault[i] in any state and clears amp_enable[i] only. The state is unaffected. clr=1 clears axis_fault bits whose inputs are currently low.
- Watchdog: any reg_wen, to any address, zeroes the counter. If the counter reaches WDOG_CYC in PWR_WAIT..RUN, set wdog_expired and go to FAULT. The counter is held at 0 in IDLE and FAULT. clr clears wdog_expired.

## Timing
- Reset: state IDLE; all outputs 0; all counters 0; seq_state=0.
- All outputs are registered. A command takes effect on the output one cycle after the reg_wen cycle.
- Counters load 0 on state entry. A transition fires in the cycle where the count equals PARAM-1, so dwell is exactly PARAM cycles.
- Simultaneous fault input and clr: the fault wins and the bit stays set.
- Simultaneous watchdog expiry and command: the command's reg_wen resets the watchdog, so there is no expiry.
- Simultaneous abort and supply loss: FAULT wins.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.
- Reset deassertion mid-sequence restarts at IDLE; no state is retained.

## Configuration
- AMP_SEQ_WDOG_EN defined: watchdog logic present as described.
- AMP_SEQ_WDOG_EN undefined:
  - no watchdog counter;
  - wdog_expired is tied to 0;
  - loss of host writes never causes FAULT.

## Structure
- Shared package amp_seq_pkg holds:
  - the state enum and its 3-bit encoding;
  - the command bit positions (PWR_REQ_BIT, CLR_BIT, MASK_LSB/MSB);
  - the default CMD_ADDR.
- One sub-module, seq_timer: a loadable saturating up-counter with a terminal-count compare. Instantiate it once for the state dwell and once for the watchdog.

## Test plan
Bench parameters: SETTLE=16, RELAY=8, STAGGER=4, WDOG=100.
- Power-up: command 0xF1 with mv_good rising 5 cycles later.
  - pwr_enable goes high 1 cycle after the command.
  - relay_on follows mv_good by 1 cycle.
  - amp_enable goes 0001, 0011, 0111, 1111 at 4-cycle spacing after 8 relay cycles.
- Supply timeout: command 0x31 with mv_good held 0. FAULT after 16 cycles, all outputs 0, seq_state=5.
- Watchdog: in RUN with no writes for 100 cycles. wdog_expired=1 and FAULT. Writes every 50 cycles keep RUN.
- Axis trip: in RUN with mask 0xF, pulse fault[2].
  - amp_enable becomes 1011, axis_fault becomes 0100, state stays RUN.
  - Command clr with pwr_req=1 and the mask restores 1111.
- Abort and recover:
  - Command 0x00 mid-STAGGER gives IDLE with all outputs 0 next cycle.
  - From FAULT, command 0x02 gives IDLE.
- Async reset: assert reset low in RUN. Outputs go 0 without waiting for a clock edge.
